train_aspect_supervisor: RTL and testbench

Onboard supervisor at the train end of the automatic signaling chain. Each time the train passes a wayside signal it samples that signal's 2-bit aspect, the same encoding the wayside signal controller drives. It then derives a speed limit, demands driver acknowledgement of restrictive aspects, and latches an emergency brake on timeout, overspeed, or a signal passed at danger (SPAD).

---
 rtl/train_aspect_supervisor_pkg.sv | 38 +++
 rtl/train_aspect_supervisor_overspeed_timer.sv | 30 +++
 rtl/train_aspect_supervisor.sv | 129 ++++++++++++
 tb/tb_train_aspect_supervisor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/train_aspect_supervisor_pkg.sv
// Shared types and helpers for the train-borne aspect supervisor:
// aspect codes, FSM states and the aspect-to-speed-limit mapping.
package train_aspect_supervisor_pkg;

   typedef enum logic [1:0] {
      RED     = 2'b00,
      YELLOW  = 2'b01,
      DYELLOW = 2'b10,
      GREEN   = 2'b11
   } aspect_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SUPERVISE = 2'd1,
      ALERT     = 2'd2,
      BRAKE     = 2'd3
   } state_t;

   // Limit in km/h for an aspect; caller narrows to the speed bus width.
   function automatic int unsigned aspect_limit(input aspect_t     a,
                                                input int unsigned v_max,
                                                input int unsigned v_dyellow,
                                                input int unsigned v_yellow);
      int unsigned lim;
      case (a)
         GREEN:   lim = v_max;
         DYELLOW: lim = v_dyellow;
         YELLOW:  lim = v_yellow;
         default: lim = 0;
      endcase
      return lim;
   endfunction

   function automatic logic is_restrictive(input aspect_t a);
      return (a == YELLOW) || (a == DYELLOW);
   endfunction

endpackage

// File: rtl/train_aspect_supervisor_overspeed_timer.sv
// Consecutive-overspeed counter: counts cycles with speed above the limit
// while enabled and flags the cycle on which the threshold is reached.
module train_aspect_supervisor_overspeed_timer #(
   parameter int unsigned N = 8
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_over,
   output logic o_hit_c
);

   localparam int unsigned CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_hit_c = i_en && i_over && (r_cnt == CNT_W'(N - 1));

   // Any break in the overspeed run, or leaving supervision, restarts the count.
   always_ff @(posedge i_clk) begin
      if (!i_clr) begin
         r_cnt <= '0;
      end else if (!i_en || !i_over || o_hit_c) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_W'(N)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/train_aspect_supervisor.sv
// Onboard aspect supervisor: derives the speed limit from sampled wayside
// aspects, enforces driver acknowledgement and latches the emergency brake.
module train_aspect_supervisor
   import train_aspect_supervisor_pkg::*;
#(
   parameter int unsigned V_MAX            = 120,
   parameter int unsigned V_DYELLOW        = 80,
   parameter int unsigned V_YELLOW         = 40,
   parameter int unsigned ACK_CYCLES       = 16,
   parameter int unsigned OVERSPEED_CYCLES = 8,
   parameter int unsigned SPEED_W          = 8
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [1:0]         aspect,
   input  logic               aspect_valid,
   input  logic               ack,
   input  logic [SPEED_W-1:0] speed,
   output logic [SPEED_W-1:0] limit,
   output logic               warn,
   output logic               brake,
   output logic               spad,
   output logic [1:0]         state
);

   localparam int unsigned TMR_W = $clog2(ACK_CYCLES + 1);

   state_t             r_state,  w_state_nxt;
   logic [SPEED_W-1:0] r_limit,  w_limit_nxt;
   logic [TMR_W-1:0]   r_timer,  w_timer_nxt;
   logic               r_spad,   w_spad_nxt;
   logic               r_warn,   w_warn_nxt;
   logic               r_brake;
   aspect_t            w_aspect;
   logic [SPEED_W-1:0] w_aspect_limit;
   logic               w_os_en;
   logic               w_os_hit;

   assign w_aspect       = aspect_t'(aspect);
   assign w_aspect_limit = SPEED_W'(aspect_limit(w_aspect, V_MAX, V_DYELLOW, V_YELLOW));
   assign w_os_en        = (r_state == SUPERVISE) && !aspect_valid;

   train_aspect_supervisor_overspeed_timer #(
      .N (OVERSPEED_CYCLES)
   ) u_overspeed_timer (
      .i_clk   (clk),
      .i_clr   (clr),
      .i_en    (w_os_en),
      .i_over  (speed > r_limit),
      .o_hit_c (w_os_hit)
   );

   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state <= IDLE;
         r_limit <= '0;
         r_timer <= '0;
         r_spad  <= 1'b0;
         r_warn  <= 1'b0;
         r_brake <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_limit <= w_limit_nxt;
         r_timer <= w_timer_nxt;
         r_spad  <= w_spad_nxt;
         r_warn  <= w_warn_nxt;
         r_brake <= (w_state_nxt == BRAKE);
      end
   end

   // A sampled aspect overrides every in-state decision, including ack.
   always_comb begin
      w_state_nxt = r_state;
      w_limit_nxt = r_limit;
      w_timer_nxt = r_timer;
      w_spad_nxt  = r_spad;
      if (aspect_valid) begin
         if (w_aspect == RED) begin
            w_state_nxt = BRAKE;
            w_limit_nxt = '0;
            w_spad_nxt  = 1'b1;
            w_timer_nxt = '0;
         end else if (r_state == BRAKE) begin
            w_limit_nxt = w_aspect_limit;
         end else if (is_restrictive(w_aspect)) begin
            w_state_nxt = ALERT;
            w_limit_nxt = w_aspect_limit;
            w_timer_nxt = TMR_W'(ACK_CYCLES);
         end else begin
            w_state_nxt = SUPERVISE;
            w_limit_nxt = w_aspect_limit;
            w_timer_nxt = '0;
         end
      end else begin
         case (r_state)
            ALERT: begin
               if (ack) begin
                  w_state_nxt = SUPERVISE;
                  w_timer_nxt = '0;
               end else if (r_timer <= TMR_W'(1)) begin
                  w_state_nxt = BRAKE;
                  w_timer_nxt = '0;
               end else begin
                  w_timer_nxt = r_timer - TMR_W'(1);
               end
            end
            SUPERVISE: begin
               if (w_os_hit) w_state_nxt = BRAKE;
            end
            BRAKE: begin
               if ((speed == '0) && ack) begin
                  w_state_nxt = SUPERVISE;
                  w_spad_nxt  = 1'b0;
               end
            end
            default: ;
         endcase
      end
      w_warn_nxt = (w_state_nxt == ALERT) ||
                   ((w_state_nxt == SUPERVISE) && (speed > w_limit_nxt));
   end

   assign limit = r_limit;
   assign warn  = r_warn;
   assign brake = r_brake;
   assign spad  = r_spad;
   assign state = r_state;

endmodule

// File: tb/tb_train_aspect_supervisor.sv
// Directed bench for train_aspect_supervisor: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (timeouts, overspeed, resets).
module tb_train_aspect_supervisor;

   localparam int unsigned SW = 8;

   typedef struct packed {
      logic          clr;
      logic [1:0]    asp;
      logic          av;
      logic          ack;
      logic [SW-1:0] speed;
      logic [1:0]    st;
      logic [SW-1:0] lim;
      logic          warn;
      logic          brake;
      logic          spad;
   } vec_t;

   localparam logic [1:0] A_R = 2'b00, A_Y = 2'b01, A_DY = 2'b10, A_G = 2'b11;
   localparam logic [1:0] S_I = 2'd0, S_S = 2'd1, S_A = 2'd2, S_B = 2'd3;

   logic          clk = 1'b0;
   logic          clr;
   logic [1:0]    aspect;
   logic          aspect_valid;
   logic          ack;
   logic [SW-1:0] speed;
   logic [SW-1:0] limit;
   logic          warn;
   logic          brake;
   logic          spad;
   logic [1:0]    state;

   int n_cmp  = 0;
   int n_fail = 0;
   int vec_id = 0;

   train_aspect_supervisor #(
      .V_MAX(120), .V_DYELLOW(80), .V_YELLOW(40),
      .ACK_CYCLES(16), .OVERSPEED_CYCLES(8), .SPEED_W(SW)
   ) dut (
      .clk(clk), .clr(clr), .aspect(aspect), .aspect_valid(aspect_valid),
      .ack(ack), .speed(speed), .limit(limit), .warn(warn), .brake(brake),
      .spad(spad), .state(state)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic c, input logic [1:0] a, input logic v,
                               input logic k, input int unsigned sp,
                               input logic [1:0] st, input int unsigned lim,
                               input logic w, input logic b, input logic s);
      vec_t r;
      r.clr = c; r.asp = a; r.av = v; r.ack = k; r.speed = SW'(sp);
      r.st = st; r.lim = SW'(lim); r.warn = w; r.brake = b; r.spad = s;
      return r;
   endfunction

   task automatic chk(input string name, input int id, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s vec=%0d actual=%0d required=%0d", name, id, act, exp);
      end
   endtask

   // Drive one vector, clock once, then compare all outputs 1ns after the edge.
   task automatic apply(input vec_t v);
      clr = v.clr; aspect = v.asp; aspect_valid = v.av; ack = v.ack; speed = v.speed;
      @(posedge clk);
      #1;
      chk("state", vec_id, int'(state), int'(v.st));
      chk("limit", vec_id, int'(limit), int'(v.lim));
      chk("warn",  vec_id, int'(warn),  int'(v.warn));
      chk("brake", vec_id, int'(brake), int'(v.brake));
      chk("spad",  vec_id, int'(spad),  int'(v.spad));
      vec_id++;
   endtask

   vec_t tbl[$];

   initial begin
      clr = 1'b0; aspect = 2'b00; aspect_valid = 1'b0; ack = 1'b0; speed = '0;
      #1;

      //             clr asp  av ack  sp  | st  lim  w  b  s
      tbl.push_back(mk(0, A_R,  0, 0,   0,  S_I,   0, 0, 0, 0));
      tbl.push_back(mk(1, A_R,  0, 0, 100,  S_I,   0, 0, 0, 0));
      tbl.push_back(mk(1, A_G,  1, 0, 100,  S_S, 120, 0, 0, 0));
      tbl.push_back(mk(1, A_G,  0, 0, 130,  S_S, 120, 1, 0, 0));
      tbl.push_back(mk(1, A_G,  0, 0, 100,  S_S, 120, 0, 0, 0));
      tbl.push_back(mk(1, A_Y,  1, 0,  30,  S_A,  40, 1, 0, 0));
      foreach (tbl[i]) apply(tbl[i]);

      // Yellow without ack: brake exactly 16 edges after the aspect edge.
      for (int i = 0; i < 15; i++) apply(mk(1, A_Y, 0, 0, 30, S_A, 40, 1, 0, 0));
      apply(mk(1, A_Y, 0, 0, 30, S_B, 40, 0, 1, 0));
      apply(mk(1, A_DY, 1, 0, 30, S_B, 80, 0, 1, 0));
      apply(mk(1, A_DY, 0, 1,  0, S_S, 80, 0, 0, 0));

      // Double yellow acked on the 5th cycle, then 8 cycles at 90 km/h.
      apply(mk(1, A_DY, 1, 0, 50, S_A, 80, 1, 0, 0));
      for (int i = 0; i < 4; i++) apply(mk(1, A_DY, 0, 0, 50, S_A, 80, 1, 0, 0));
      apply(mk(1, A_DY, 0, 1, 50, S_S, 80, 0, 0, 0));
      for (int i = 0; i < 7; i++) apply(mk(1, A_DY, 0, 0, 90, S_S, 80, 1, 0, 0));
      apply(mk(1, A_DY, 0, 0, 90, S_B, 80, 0, 1, 0));
      apply(mk(1, A_DY, 0, 1, 90, S_B, 80, 0, 1, 0));
      apply(mk(1, A_DY, 0, 1,  0, S_S, 80, 0, 0, 0));

      // Red in SUPERVISE, release, then aspect-beats-ack cases.
      apply(mk(1, A_R,  1, 0, 50, S_B,   0, 0, 1, 1));
      apply(mk(1, A_R,  0, 1,  0, S_S,   0, 0, 0, 0));
      apply(mk(1, A_Y,  1, 0,  0, S_A,  40, 1, 0, 0));
      apply(mk(1, A_Y,  1, 1,  0, S_A,  40, 1, 0, 0));
      apply(mk(1, A_G,  1, 1,  0, S_S, 120, 0, 0, 0));
      apply(mk(1, A_R,  1, 0,  0, S_B,   0, 0, 1, 1));
      apply(mk(1, A_Y,  1, 0, 10, S_B,  40, 0, 1, 1));
      apply(mk(1, A_Y,  0, 1,  0, S_S,  40, 0, 0, 0));

      // Ack held from before the alert acknowledges on the first cycle.
      apply(mk(1, A_DY, 1, 1,  0, S_A,  80, 1, 0, 0));
      apply(mk(1, A_DY, 0, 1,  0, S_S,  80, 0, 0, 0));

      // Second restrictive aspect restarts the acknowledge window.
      apply(mk(1, A_Y, 1, 0, 0, S_A, 40, 1, 0, 0));
      for (int i = 0; i < 10; i++) apply(mk(1, A_Y, 0, 0, 0, S_A, 40, 1, 0, 0));
      apply(mk(1, A_Y, 1, 0, 0, S_A, 40, 1, 0, 0));
      for (int i = 0; i < 15; i++) apply(mk(1, A_Y, 0, 0, 0, S_A, 40, 1, 0, 0));
      apply(mk(1, A_Y, 0, 0, 0, S_B, 40, 0, 1, 0));

      // Reset aborts BRAKE, ALERT, and wins over a simultaneous aspect.
      apply(mk(0, A_Y, 0, 0, 0, S_I,   0, 0, 0, 0));
      apply(mk(1, A_G, 1, 0, 0, S_S, 120, 0, 0, 0));
      apply(mk(1, A_Y, 1, 0, 0, S_A,  40, 1, 0, 0));
      apply(mk(0, A_Y, 0, 0, 0, S_I,   0, 0, 0, 0));
      apply(mk(1, A_R, 1, 0, 0, S_B,   0, 0, 1, 1));
      apply(mk(0, A_R, 0, 1, 0, S_I,   0, 0, 0, 0));
      apply(mk(0, A_G, 1, 0, 0, S_I,   0, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
